// File: rtl/fifo1_rr_enq_arbiter.sv
// Round-robin (optionally burst-locked) arbiter sharing the enq port of a single-entry FIFO.
// The winning request is captured in a one-entry stage and forwarded as {source id, data}.
`timescale 1ns/1ps
module fifo1_rr_enq_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned IDW   = 2,
    parameter int unsigned BURST = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req_ena,
    input  logic [NREQ*DW-1:0]    req_v,
    output logic [NREQ-1:0]       req_rdy,
    output logic                  fifo_enq_ena,
    output logic [IDW+DW-1:0]     fifo_enq_v,
    input  logic                  fifo_enq_rdy,
    output logic                  busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;

    logic               r_stage_valid;
    logic [IDW-1:0]     r_stage_id;
    logic [DW-1:0]      r_stage_data;
    logic [PW-1:0]      r_ptr;
    logic [CW-1:0]      r_cnt;

    logic               w_drain;
    logic               w_can_accept;
    logic               w_any;
    logic               w_accept;
    logic [PW-1:0]      w_win;
    logic [DW-1:0]      w_win_data;
    logic [CW:0]        w_cnt_new;
    logic [PW-1:0]      w_ptr_nxt;
    logic [CW-1:0]      w_cnt_nxt;

    // (a + b) mod NREQ for a < NREQ and b <= NREQ, without a divider
    function automatic logic [PW-1:0] f_wrap_add(input logic [PW-1:0] a, input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return PW'(s);
    endfunction

    // Scan from the priority owner upward, first active request wins
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_any && req_ena[f_wrap_add(r_ptr, k)]) begin
                w_any = 1'b1;
                w_win = f_wrap_add(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PW'(i)) begin
                w_win_data = req_v[i*DW +: DW];
            end
        end
    end

    assign w_drain      = r_stage_valid & fifo_enq_rdy;
    assign w_can_accept = !r_stage_valid | w_drain;
    assign w_accept     = w_any & w_can_accept;

    // Burst bookkeeping: owner keeps priority until it has taken BURST words in a row
    always_comb begin
        w_cnt_new = (w_win == r_ptr) ? ((CW+1)'(r_cnt) + (CW+1)'(1)) : (CW+1)'(1);
        w_ptr_nxt = w_win;
        w_cnt_nxt = CW'(w_cnt_new);
        if (w_cnt_new == (CW+1)'(BURST)) begin
            w_ptr_nxt = f_wrap_add(w_win, 1);
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stage_valid <= 1'b0;
            r_stage_id    <= '0;
            r_stage_data  <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
        end else if (w_accept) begin
            r_stage_valid <= 1'b1;
            r_stage_id    <= IDW'(w_win);
            r_stage_data  <= w_win_data;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
        end else if (w_drain) begin
            r_stage_valid <= 1'b0;
        end
    end

    // Handshakes are masked while reset is held so nothing moves in the reset cycle
    assign req_rdy      = (nRST && w_accept) ? (NREQ'(1) << w_win) : '0;
    assign fifo_enq_ena = nRST & w_drain;
    assign busy         = nRST & r_stage_valid;
    assign fifo_enq_v   = {r_stage_id, r_stage_data};

endmodule
